// File: rtl/elevator_scheduler.sv
// rtl/elevator_scheduler.sv - LOOK-policy elevator call scheduler with door timing
// Holds inside/hall calls, picks direction, commands motion and clears calls at each stop.
module elevator_scheduler #(
  parameter int NUM_FLOORS  = 8,
  parameter int FLOOR_W     = 3,
  parameter int DOOR_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  input  logic [1:0]            req_type,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  arrived,
  output logic [NUM_FLOORS-1:0] pend_inside,
  output logic [NUM_FLOORS-1:0] pend_up,
  output logic [NUM_FLOORS-1:0] pend_down,
  output logic                  direction,
  output logic                  should_move,
  output logic                  door_open,
  output logic                  busy
);
  localparam int CNT_W = $clog2(DOOR_CYCLES + 1);
  localparam logic [1:0] REQ_INSIDE = 2'b00;
  localparam logic [1:0] REQ_UP     = 2'b01;
  localparam logic [1:0] REQ_DOWN   = 2'b10;

  typedef enum logic [1:0] {IDLE, MOVING, DOOR} state_t;

  state_t                state, state_n;
  logic [CNT_W-1:0]      door_cnt, door_cnt_n;
  logic [NUM_FLOORS-1:0] pend_inside_n, pend_up_n, pend_down_n;
  logic                  direction_n, should_move_n, door_open_n;
  logic [NUM_FLOORS-1:0] cur_bit, req_bit, any_pend;
  logic [NUM_FLOORS-1:0] set_in, set_up, set_dn, clr_in, clr_up, clr_dn;
  logic                  ahead, here_in, here_up, here_dn, here_dir, here_any, stop_here;
  logic                  req_ok, door_absorb, enter_door;

  always_comb begin
    cur_bit  = '0;
    req_bit  = '0;
    ahead    = 1'b0;
    any_pend = pend_inside | pend_up | pend_down;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      cur_bit[i] = (int'(cur_floor) == i);
      req_bit[i] = (int'(req_floor) == i);
      if (any_pend[i] && (direction ? (i > int'(cur_floor)) : (i < int'(cur_floor))))
        ahead = 1'b1;
    end
  end

  assign here_in  = |(pend_inside & cur_bit);
  assign here_up  = |(pend_up & cur_bit);
  assign here_dn  = |(pend_down & cur_bit);
  assign here_dir = here_in | (direction ? here_up : here_dn);
  assign here_any = here_dir | here_up | here_dn;
  // An opposite-direction hall call here only stops the car once nothing lies ahead;
  // stopping for it earlier would reopen the door forever without serving the calls ahead.
  assign stop_here = here_dir | (!ahead & here_any);

  assign req_ok = req_valid && (req_type != 2'b11) && (int'(req_floor) < NUM_FLOORS)
                  && !(req_type == REQ_UP && int'(req_floor) == NUM_FLOORS - 1)
                  && !(req_type == REQ_DOWN && req_floor == '0);

  assign door_absorb = req_ok && (state == DOOR) && (req_floor == cur_floor)
                       && (req_type == REQ_INSIDE || (req_type == REQ_UP && direction)
                           || (req_type == REQ_DOWN && !direction));

  always_comb begin
    state_n       = state;
    direction_n   = direction;
    should_move_n = should_move;
    door_open_n   = door_open;
    door_cnt_n    = door_cnt;
    enter_door    = 1'b0;
    case (state)
      IDLE: begin
        if (|any_pend) begin
          if (stop_here) begin
            enter_door = 1'b1;
          end else begin
            state_n       = MOVING;
            should_move_n = 1'b1;
            if (!ahead) direction_n = !direction;
          end
        end
      end
      MOVING: begin
        if (arrived && stop_here) enter_door = 1'b1;
      end
      DOOR: begin
        if (door_absorb) begin
          door_cnt_n = CNT_W'(1);
        end else if (door_cnt >= CNT_W'(DOOR_CYCLES)) begin
          state_n     = IDLE;
          door_open_n = 1'b0;
          door_cnt_n  = '0;
        end else begin
          door_cnt_n = door_cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    if (enter_door) begin
      state_n       = DOOR;
      should_move_n = 1'b0;
      door_open_n   = 1'b1;
      door_cnt_n    = CNT_W'(1);
      if (!ahead && (direction ? here_dn : here_up)) direction_n = !direction;
    end

    // Stop-clears apply first so a request landing on the entry edge still sets its bit.
    clr_in = enter_door ? cur_bit : '0;
    clr_up = (enter_door && (direction || !ahead)) ? cur_bit : '0;
    clr_dn = (enter_door && (!direction || !ahead)) ? cur_bit : '0;
    set_in = (req_ok && !door_absorb && req_type == REQ_INSIDE) ? req_bit : '0;
    set_up = (req_ok && !door_absorb && req_type == REQ_UP) ? req_bit : '0;
    set_dn = (req_ok && !door_absorb && req_type == REQ_DOWN) ? req_bit : '0;
    pend_inside_n = (pend_inside & ~clr_in) | set_in;
    pend_up_n     = (pend_up & ~clr_up) | set_up;
    pend_down_n   = (pend_down & ~clr_dn) | set_dn;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      door_cnt    <= '0;
      pend_inside <= '0;
      pend_up     <= '0;
      pend_down   <= '0;
      direction   <= 1'b1;
      should_move <= 1'b0;
      door_open   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      door_cnt    <= door_cnt_n;
      pend_inside <= pend_inside_n;
      pend_up     <= pend_up_n;
      pend_down   <= pend_down_n;
      direction   <= direction_n;
      should_move <= should_move_n;
      door_open   <= door_open_n;
      busy        <= (state_n != IDLE);
    end
  end
endmodule

// File: tb/tb_elevator_scheduler.sv
// tb/tb_elevator_scheduler.sv - self-checking bench for elevator_scheduler
// Directed scenarios then random calls, all against a call-list reference model.
module tb_elevator_scheduler;
  localparam int NF = 8;
  localparam int FW = 3;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          reset, req_valid, arrived;
  logic [FW-1:0] req_floor, cur_floor;
  logic [1:0]    req_type;
  logic [NF-1:0] pend_inside, pend_up, pend_down;
  logic          direction, should_move, door_open, busy;

  elevator_scheduler #(.NUM_FLOORS(NF), .FLOOR_W(FW), .DOOR_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_floor(req_floor),
    .req_type(req_type), .cur_floor(cur_floor), .arrived(arrived),
    .pend_inside(pend_inside), .pend_up(pend_up), .pend_down(pend_down),
    .direction(direction), .should_move(should_move), .door_open(door_open), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference: call lists per floor, car mode (0 idle, 1 travelling, 2 door), door cycles left.
  bit [NF-1:0] m_in, m_up, m_dn;
  int          m_mode, m_left;
  bit          m_dir, m_mv, m_door;
  int          pos, trav, trav_len;
  bit          rnd_travel;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit ahead, hin, hup, hdn, stop, ok, absorb, enter;
    int c, f;
    if (reset) begin
      m_in = '0; m_up = '0; m_dn = '0;
      m_mode = 0; m_dir = 1'b1; m_mv = 1'b0; m_door = 1'b0; m_left = 0;
      return;
    end
    c = pos; f = int'(req_floor);
    ahead = 1'b0; enter = 1'b0;
    for (int i = 0; i < NF; i++)
      if ((m_in[i] || m_up[i] || m_dn[i]) && (m_dir ? i > c : i < c)) ahead = 1'b1;
    hin = m_in[c]; hup = m_up[c]; hdn = m_dn[c];
    stop = hin || (m_dir ? hup : hdn) || (!ahead && (hup || hdn));
    ok = req_valid && req_type != 2'd3 && f < NF && !(req_type == 2'd1 && f == NF - 1)
         && !(req_type == 2'd2 && f == 0);
    absorb = ok && m_mode == 2 && f == c
             && (req_type == 2'd0 || (req_type == 2'd1 && m_dir) || (req_type == 2'd2 && !m_dir));
    case (m_mode)
      0: if ((m_in | m_up | m_dn) != 0) begin
           if (stop) enter = 1'b1;
           else begin m_mode = 1; m_mv = 1'b1; if (!ahead) m_dir = !m_dir; end
         end
      1: if (arrived && stop) enter = 1'b1;
      default: if (absorb) m_left = DC;
               else if (m_left == 1) begin m_mode = 0; m_door = 1'b0; m_left = 0; end
               else m_left--;
    endcase
    if (enter) begin
      m_in[c] = 1'b0;
      if (m_dir || !ahead) m_up[c] = 1'b0;
      if (!m_dir || !ahead) m_dn[c] = 1'b0;
      if (!ahead && (m_dir ? hdn : hup)) m_dir = !m_dir;
      m_mode = 2; m_mv = 1'b0; m_door = 1'b1; m_left = DC;
    end
    if (ok && !absorb)
      case (req_type)
        2'd0: m_in[f] = 1'b1;
        2'd1: m_up[f] = 1'b1;
        default: m_dn[f] = 1'b1;
      endcase
  endtask

  // One clock: advance the model, compare every output, then move the simulated car.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("pend_inside", 32'(pend_inside), 32'(m_in));
    check("pend_up", 32'(pend_up), 32'(m_up));
    check("pend_down", 32'(pend_down), 32'(m_dn));
    check("direction", 32'(direction), 32'(m_dir));
    check("should_move", 32'(should_move), 32'(m_mv));
    check("door_open", 32'(door_open), 32'(m_door));
    check("busy", 32'(busy), 32'(m_mode != 0));
    req_valid = 1'b0;
    arrived   = 1'b0;
    if (m_mv) begin
      trav++;
      if (trav >= trav_len) begin
        trav = 0;
        pos  = m_dir ? pos + 1 : pos - 1;
        arrived = 1'b1;
        check("car_in_range", 32'(pos >= 0 && pos < NF), 32'd1);
        if (pos < 0) pos = 0;
        if (pos >= NF) pos = NF - 1;
        trav_len = rnd_travel ? int'($urandom_range(1, 4)) : 2;
      end
    end else begin
      trav = 0;
    end
    cur_floor = pos[FW-1:0];
  endtask

  task automatic req(input int f, input int t);
    req_valid = 1'b1;
    req_floor = FW'(f);
    req_type  = 2'(t);
    tick();
  endtask

  task automatic do_reset(input int p);
    pos = p;
    cur_floor = FW'(p);
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic run_until_door(input string tag);
    int n = 0;
    while (!door_open && n < 200) begin tick(); n++; end
    check(tag, 32'(n < 200), 32'd1);
  endtask

  task automatic count_door(input string tag, input int exp);
    int n = 0;
    while (door_open && n < 40) begin n++; tick(); end
    check(tag, 32'(n), 32'(exp));
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_floor = '0; req_type = '0; arrived = 1'b0;
    pos = 0; cur_floor = '0; trav = 0; trav_len = 2; rnd_travel = 1'b0;

    // Reset state and single inside call to floor 5.
    do_reset(0);
    check("rst_dir", 32'(direction), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    req(5, 0);
    check("t1_pend", 32'(pend_inside), 32'h20);
    check("t1_move_early", 32'(should_move), 32'd0);
    tick();
    check("t1_move", 32'(should_move), 32'd1);
    check("t1_dir", 32'(direction), 32'd1);
    run_until_door("t2_door_timeout");
    check("t2_floor", 32'(pos), 32'd5);
    check("t2_pend", 32'(pend_inside), 32'h0);
    count_door("t2_door_len", DC);
    check("t2_idle", 32'(busy), 32'd0);

    // Hall calls both ways at 4 while travelling up to 6.
    do_reset(2);
    req(6, 0);
    tick();
    req(4, 2);
    req(4, 1);
    run_until_door("t3_door1_timeout");
    check("t3_floor1", 32'(pos), 32'd4);
    check("t3_up_cleared", 32'(pend_up), 32'h0);
    check("t3_down_kept", 32'(pend_down), 32'h10);
    count_door("t3_door1_len", DC);
    run_until_door("t3_door2_timeout");
    check("t3_floor2", 32'(pos), 32'd6);
    check("t3_in_cleared", 32'(pend_inside), 32'h0);
    count_door("t3_door2_len", DC);
    run_until_door("t3_door3_timeout");
    check("t3_floor3", 32'(pos), 32'd4);
    check("t3_down_cleared", 32'(pend_down), 32'h0);
    check("t3_dir_down", 32'(direction), 32'd0);
    count_door("t3_door3_len", DC);

    // Calls that must be ignored.
    do_reset(3);
    req(7, 1);
    req(0, 2);
    req(2, 3);
    tick();
    check("t4_pend", 32'({pend_inside, pend_up, pend_down}), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);

    // Inside call at the open-door floor restarts the door.
    do_reset(3);
    req(3, 0);
    tick();
    check("t5_door", 32'(door_open), 32'd1);
    tick();
    req(3, 0);
    check("t5_absorbed", 32'(pend_inside), 32'h0);
    count_door("t5_door_held", DC);

    // Reset in the middle of a trip.
    do_reset(0);
    req(7, 0);
    req(5, 2);
    tick(); tick(); tick();
    check("t6_moving", 32'(should_move), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_pend", 32'({pend_inside, pend_up, pend_down}), 32'd0);
    check("t6_outs", 32'({direction, should_move, door_open, busy}), 32'b1000);

    // Random calls, travel times, stray arrivals and rare resets.
    rnd_travel = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      reset = ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b1;
        req_floor = FW'($urandom_range(0, NF - 1));
        req_type  = 2'($urandom_range(0, 3));
      end
      if (!m_mv && $urandom_range(0, 7) == 0) arrived = 1'b1;
      tick();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
